// File: rtl/efpga_mae_multi_if.sv
// Operand/result bundle between eFPGA fabric routing and one MAE site.
// The fabric drives the master side and the MAE implements the slave side.
interface efpga_mae_multi_if #(
    parameter int unsigned INPUT_WIDTH  = 18,
    parameter int unsigned OUTPUT_WIDTH = 40
);
    logic                    in_valid;
    logic [2:0]              mode;
    logic                    signed_en;
    logic                    sat_en;
    logic                    acc_clr;
    logic [INPUT_WIDTH-1:0]  a;
    logic [INPUT_WIDTH-1:0]  b;
    logic [OUTPUT_WIDTH-1:0] c;
    logic                    out_valid;
    logic [OUTPUT_WIDTH-1:0] y;
    logic                    ovf;

    modport master (
        output in_valid, mode, signed_en, sat_en, acc_clr, a, b, c,
        input  out_valid, y, ovf
    );

    modport slave (
        input  in_valid, mode, signed_en, sat_en, acc_clr, a, b, c,
        output out_valid, y, ovf
    );
endinterface

// File: rtl/efpga_mae_multi.sv
// Mode-selectable multiply-accumulate element: optional input and product
// register stages in front of the result register, which doubles as accumulator.
module efpga_mae_multi #(
    parameter int unsigned INPUT_WIDTH  = 18,
    parameter int unsigned OUTPUT_WIDTH = 40,
    parameter int unsigned REG_IN       = 1,
    parameter int unsigned PIPE_MULT    = 1
) (
    input  logic             clk,
    input  logic             reset,
    efpga_mae_multi_if.slave bus
);
    localparam int unsigned IW = INPUT_WIDTH;
    localparam int unsigned OW = OUTPUT_WIDTH;
    localparam int unsigned PW = 2 * INPUT_WIDTH;
    localparam int unsigned EW = OUTPUT_WIDTH + 2;

    localparam logic [2:0] MODE_ADD       = 3'd0;
    localparam logic [2:0] MODE_MULT      = 3'd1;
    localparam logic [2:0] MODE_MULT_ADDC = 3'd2;
    localparam logic [2:0] MODE_ACC       = 3'd3;
    localparam logic [2:0] MODE_MACC      = 3'd4;

    localparam logic [OW-1:0] SMAX = {1'b0, {(OW - 1){1'b1}}};
    localparam logic [OW-1:0] SMIN = {1'b1, {(OW - 1){1'b0}}};

    typedef struct packed {
        logic          valid;
        logic [2:0]    mode;
        logic          signed_en;
        logic          sat_en;
        logic          acc_clr;
        logic [IW-1:0] a;
        logic [IW-1:0] b;
        logic [OW-1:0] c;
    } op_t;

    typedef struct packed {
        op_t           op;
        logic [PW-1:0] prod;
    } mul_op_t;

    op_t     in_d;
    op_t     in_s;
    mul_op_t mul_d;
    mul_op_t mul_s;

    logic [OW-1:0] y_q;
    logic          ovf_q;
    logic          out_valid_q;

    assign in_d = '{
        valid:     bus.in_valid,
        mode:      bus.mode,
        signed_en: bus.signed_en,
        sat_en:    bus.sat_en,
        acc_clr:   bus.acc_clr,
        a:         bus.a,
        b:         bus.b,
        c:         bus.c
    };

    // Optional input stage; controls travel with their operands
    generate
        if (REG_IN != 0) begin : g_in_reg
            op_t q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= '0;
                end else begin
                    q <= in_d;
                end
            end
            assign in_s = q;
        end else begin : g_in_comb
            assign in_s = in_d;
        end
    endgenerate

    // Operands extended to PW bits; low PW bits of the product are then exact
    // for both signed and unsigned operands, so one multiplier serves both.
    logic [PW-1:0] a_x;
    logic [PW-1:0] b_x;

    always_comb begin
        a_x        = {{(PW - IW){in_s.signed_en & in_s.a[IW-1]}}, in_s.a};
        b_x        = {{(PW - IW){in_s.signed_en & in_s.b[IW-1]}}, in_s.b};
        mul_d.op   = in_s;
        mul_d.prod = a_x * b_x;
    end

    // Optional product stage
    generate
        if (PIPE_MULT != 0) begin : g_mul_reg
            mul_op_t q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= '0;
                end else begin
                    q <= mul_d;
                end
            end
            assign mul_s = q;
        end else begin : g_mul_comb
            assign mul_s = mul_d;
        end
    endgenerate

    logic          sx;
    logic          known;
    logic [EW-1:0] a_e;
    logic [EW-1:0] b_e;
    logic [EW-1:0] p_e;
    logic [EW-1:0] c_e;
    logic [EW-1:0] y_e;
    logic [EW-1:0] term;
    logic [EW-1:0] base;
    logic [EW-1:0] r;
    logic [OW-1:0] res_d;
    logic          ovf_d;

    // Term/base selection, exact sum in EW bits, then range check and clamp
    always_comb begin
        sx    = mul_s.op.signed_en;
        a_e   = {{(EW - IW){sx & mul_s.op.a[IW-1]}}, mul_s.op.a};
        b_e   = {{(EW - IW){sx & mul_s.op.b[IW-1]}}, mul_s.op.b};
        p_e   = {{(EW - PW){sx & mul_s.prod[PW-1]}}, mul_s.prod};
        c_e   = {{2{sx & mul_s.op.c[OW-1]}}, mul_s.op.c};
        y_e   = {{2{sx & y_q[OW-1]}}, y_q};
        term  = '0;
        base  = '0;
        known = 1'b1;

        case (mul_s.op.mode)
            MODE_ADD: begin
                term = a_e;
                base = b_e;
            end
            MODE_MULT: begin
                term = p_e;
            end
            MODE_MULT_ADDC: begin
                term = p_e;
                base = c_e;
            end
            MODE_ACC: begin
                term = a_e;
                base = mul_s.op.acc_clr ? '0 : y_e;
            end
            MODE_MACC: begin
                term = p_e;
                base = mul_s.op.acc_clr ? '0 : y_e;
            end
            default: begin
                known = 1'b0;
            end
        endcase

        r = term + base;

        // Unsigned sums are never negative, so only the upper bound can be hit
        if (sx) begin
            ovf_d = (r[EW-1:OW-1] != {3{r[EW-1]}});
        end else begin
            ovf_d = |r[EW-1:OW];
        end

        res_d = r[OW-1:0];
        if (mul_s.op.sat_en && ovf_d) begin
            if (sx) begin
                res_d = r[EW-1] ? SMIN : SMAX;
            end else begin
                res_d = '1;
            end
        end

        if (!known) begin
            res_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Result/accumulator register: y and ovf only move on a valid op
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= mul_s.op.valid;
            if (mul_s.op.valid) begin
                y_q   <= res_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign bus.y         = y_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;

endmodule
